// File: rtl/asr_shift_sequencer.sv
// Multi-cycle arithmetic-right-shift sequencer: one sign-filling shift per clock, result in dout.
// Optional sticky output (OR of all shifted-out bits) is enabled by defining ASR_SEQ_STICKY_EN.
module asr_shift_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] din,
  input  logic [3:0] shamt,
  output logic       busy,
  output logic       done,
`ifdef ASR_SEQ_STICKY_EN
  output logic       sticky,
`endif
  output logic [9:0] dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] work_q, work_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] dout_q, dout_d;

  logic       accept;
  logic       last_shift;
  logic [3:0] k_clamped;
  logic [9:0] work_shr;

  assign accept     = start && (state_q != SHIFT);
  assign k_clamped  = (shamt > 4'd9) ? 4'd9 : shamt;
  assign last_shift = (state_q == SHIFT) && (cnt_q <= 4'd1);
  assign work_shr   = {work_q[9], work_q[9:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (k_clamped == 4'd0) ? DONE : SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (last_shift) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == SHIFT);
    done = (state_q == DONE);
    dout = dout_q;
  end

  // A zero-length job publishes din straight away; otherwise dout changes only on the final shift.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (accept) begin
      work_d = din;
      cnt_d  = k_clamped;
      if (k_clamped == 4'd0) begin
        dout_d = din;
      end
    end else if (state_q == SHIFT) begin
      work_d = work_shr;
      cnt_d  = cnt_q - 4'd1;
      if (last_shift) begin
        dout_d = work_shr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= 10'h000;
      cnt_q  <= 4'd0;
      dout_q <= 10'h000;
    end else begin
      work_q <= work_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

`ifdef ASR_SEQ_STICKY_EN
  logic acc_q, acc_d;
  logic sticky_q, sticky_d;

  // acc collects bits lost so far; sticky is published alongside dout and held with it.
  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (accept) begin
      acc_d = 1'b0;
      if (k_clamped == 4'd0) begin
        sticky_d = 1'b0;
      end
    end else if (state_q == SHIFT) begin
      acc_d = acc_q | work_q[0];
      if (last_shift) begin
        sticky_d = acc_q | work_q[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`endif

endmodule

// File: tb/tb_asr_shift_sequencer.sv
// Self-checking bench for asr_shift_sequencer: scoreboard of expected results popped on each done pulse.
// Sticky checks are compiled in when ASR_SEQ_STICKY_EN is defined.
module tb_asr_shift_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] din;
  logic [3:0] shamt;
  logic       busy;
  logic       done;
  logic [9:0] dout;
`ifdef ASR_SEQ_STICKY_EN
  logic       sticky;
`endif

  typedef struct packed {
    logic [9:0] dout;
    logic       sticky;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] hold_dout;
  logic       hold_sticky;
  int         nChecks = 0;
  int         nErrors = 0;

  asr_shift_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .din   (din),
    .shamt (shamt),
    .busy  (busy),
    .done  (done),
`ifdef ASR_SEQ_STICKY_EN
    .sticky(sticky),
`endif
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    nChecks++;
    if (got !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expected);
    end
  endtask

  function automatic int clampK(input logic [3:0] s);
    return (s > 4'd9) ? 9 : int'(s);
  endfunction

  function automatic exp_t model(input logic [9:0] d, input logic [3:0] s);
    exp_t              e;
    logic signed [9:0] sd;
    logic [9:0]        mask;
    int                k;
    k        = clampK(s);
    sd       = d;
    mask     = 10'((1 << k) - 1);
    e.dout   = 10'(sd >>> k);
    e.sticky = |(d & mask);
    return e;
  endfunction

  // Called at a negedge: presents a job so the following posedge accepts it.
  task automatic applyStimulus(input logic [9:0] d, input logic [3:0] s);
    din   = d;
    shamt = s;
    start = 1'b1;
    sb.push_back(model(d, s));
  endtask

  task automatic waitForDone(input int k, input bit inject, input bit chain,
                             input logic [9:0] nd, input logic [3:0] ns);
    int bcnt = 0;
    int lat  = 99;
    bit seen = 0;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clk);
      if (inject && cyc == 2) start = 1'b0;
      if (done) begin
        seen = 1;
        lat  = cyc;
        checkOutput("busy_in_done", 32'(busy), 32'd0);
      end else if (busy) begin
        bcnt++;
      end
      if (inject && cyc == 1) begin
        start = 1'b1;
        din   = 10'h3FF;
        shamt = 4'd0;
      end
    end
    checkOutput("latency", 32'(lat), 32'(k + 1));
    checkOutput("busy_cycles", 32'(bcnt), 32'(k));
    if (chain && seen) applyStimulus(nd, ns);
  endtask

  task automatic runJob(input logic [9:0] d, input logic [3:0] s, input bit inject);
    @(negedge clk);
    applyStimulus(d, s);
    waitForDone(clampK(s), inject, 1'b0, 10'h000, 4'd0);
    repeat (2) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("dout", 32'(dout), 32'(e.dout));
`ifdef ASR_SEQ_STICKY_EN
          checkOutput("sticky", 32'(sticky), 32'(e.sticky));
`endif
          hold_dout   = e.dout;
          hold_sticky = e.sticky;
        end
      end else begin
        checkOutput("dout_hold", 32'(dout), 32'(hold_dout));
`ifdef ASR_SEQ_STICKY_EN
        checkOutput("sticky_hold", 32'(sticky), 32'(hold_sticky));
`endif
      end
    end
  end

  initial begin
    hold_dout   = 10'h000;
    hold_sticky = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    din   = 10'h000;
    shamt = 4'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_dout", 32'(dout), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    runJob(10'h200, 4'd3, 1'b0);
    runJob(10'h155, 4'd2, 1'b0);
    runJob(10'h0A7, 4'd0, 1'b0);
    runJob(10'h200, 4'd12, 1'b0);
    runJob(10'h0AA, 4'd15, 1'b0);
    runJob(10'h1F3, 4'd5, 1'b1);

    // Back-to-back: second job presented in the DONE cycle of the first.
    @(negedge clk);
    applyStimulus(10'h2B4, 4'd4);
    waitForDone(4, 1'b0, 1'b1, 10'h07F, 4'd1);
    waitForDone(1, 1'b0, 1'b0, 10'h000, 4'd0);
    repeat (2) @(negedge clk);

    // Abort a long job with reset part-way through SHIFT.
    applyStimulus(10'h2AA, 4'd9);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("busy_before_abort", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_dout", 32'(dout), 32'd0);
`ifdef ASR_SEQ_STICKY_EN
    checkOutput("abort_sticky", 32'(sticky), 32'd0);
`endif
    sb.delete();
    hold_dout   = 10'h000;
    hold_sticky = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(10'h301, 4'd6);
    waitForDone(6, 1'b0, 1'b0, 10'h000, 4'd0);
    repeat (2) @(negedge clk);

    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/asr_shift_sequencer.md
ASR_SHIFT_SEQUENCER -- requirements
Module: asr_shift_sequencer

Interface
REQ-001 SHALL have no parameters; data width is fixed at 10 bits, two's-complement.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to begin a shift job.
REQ-005 SHALL have port din, input, 10, signed operand; sampled when start is accepted.
REQ-006 SHALL have port shamt, input, 4, requested arithmetic-right shift amount; sampled when start is accepted.
REQ-007 SHALL have port busy, output, 1, high while a job is in progress (state SHIFT).
REQ-008 SHALL have port done, output, 1, single-cycle pulse marking a valid result.
REQ-009 SHALL have port dout, output, 10, result register.

Function
REQ-010 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-011 SHALL accept start only in IDLE or DONE; start in SHIFT SHALL be ignored, with no effect on state, operands or count.
REQ-012 On accept, SHALL load the work register with din and the down-counter with min(shamt, 9).
REQ-013 shamt values 10..15 SHALL clamp to 9; the result then equals 10 copies of din[9].
REQ-014 On accept with clamped count k>0, SHALL enter SHIFT; with k=0, SHALL enter DONE directly.
REQ-015 In SHIFT, each cycle SHALL shift the work register right 1 bit with sign fill (bit9 kept, bit i <- bit i+1) and decrement the counter.
REQ-016 SHALL leave SHIFT for DONE in the cycle the counter goes from 1 to 0.
REQ-017 done SHALL be high for exactly one cycle, in state DONE, which occurs k+1 clock edges after the accepting edge.
REQ-018 dout SHALL update only on entry to DONE and SHALL hold its value until the next DONE.
REQ-019 DONE SHALL return to IDLE next cycle unless start is high, in which case a new job is accepted (back-to-back, no idle bubble).
REQ-020 busy SHALL be low in IDLE and DONE and high throughout SHIFT.

Reset
REQ-021 While rst_n=0, SHALL force state IDLE, busy=0, done=0, dout=10'h000, counter=0 and work register=0, independent of clk.
REQ-022 Reset asserted mid-job SHALL abort the job with no done pulse; after release the block SHALL sit in IDLE and accept start on the first clk edge.

Configuration
REQ-023 Macro ASR_SEQ_STICKY_EN SHALL control a sticky-bit feature.
REQ-024 With ASR_SEQ_STICKY_EN defined, SHALL add output sticky (1 bit): the OR of all bits shifted out of bit 0 during the job, cleared on accept, updated with dout and held with it, reset value 0.
REQ-025 Without ASR_SEQ_STICKY_EN, the port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 din=10'h200, shamt=3 -> done 4 edges after accept, dout=10'h3C0, busy high for 3 cycles.
REQ-027 din=10'h155, shamt=2 -> dout=10'h055; with ASR_SEQ_STICKY_EN, sticky=1.
REQ-028 din=10'h0A7, shamt=0 -> no busy, done on the next edge, dout=10'h0A7, sticky=0.
REQ-029 din=10'h200, shamt=12 -> clamped to 9, done 10 edges after accept, dout=10'h3FF.
REQ-030 start pulsed with a different din/shamt during SHIFT -> ignored, original result delivered; start held high in DONE -> new job accepted with no idle cycle.
REQ-031 rst_n dropped during SHIFT of a shamt=9 job -> outputs immediately zero, no done; after release, a new job completes normally.
